// File: rtl/alu_exec_stage.sv
// Pipelined execute stage: owns the ID/EX and EX/MEM registers and resolves
// operand forwarding for an external combinational ALU.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  aluop_t;
endpackage

module alu_exec_stage
  import cpu_types_pkg::*;
(
  input  logic         CLK,
  input  logic         RST,
  input  logic         stall,
  input  logic         flush,
  input  logic         id_valid,
  input  aluop_t       id_aluop,
  input  logic [1:0]   id_alusrc,
  input  logic [4:0]   id_shamt,
  input  logic         id_extop,
  input  logic [15:0]  id_immed,
  input  logic [4:0]   id_rs,
  input  logic [4:0]   id_rt,
  input  logic [4:0]   id_rd,
  input  logic         id_regwen,
  input  logic         id_memread,
  input  logic         id_memwrite,
  input  word_t        id_rdat1,
  input  word_t        id_rdat2,
  input  logic         wb_regwen,
  input  logic [4:0]   wb_rd,
  input  word_t        wb_wdat,
  output word_t        porta,
  output word_t        portb,
  output word_t        rdat2,
  output aluop_t       aluop,
  output logic [1:0]   ALUsrc,
  output logic [4:0]   shamt,
  output logic         extop,
  output logic [15:0]  immed,
  input  word_t        outport,
  input  logic         neg_f,
  input  logic         over_f,
  input  logic         zero_f,
  output logic         ex_valid,
  output logic         ex_regwen,
  output logic         ex_memread,
  output logic         ex_memwrite,
  output logic [4:0]   ex_rd,
  output word_t        ex_result,
  output word_t        ex_store,
  output logic         ex_neg,
  output logic         ex_over,
  output logic         ex_zero
);

  typedef struct packed {
    logic        valid;
    aluop_t      aluop;
    logic [1:0]  alusrc;
    logic [4:0]  shamt;
    logic        extop;
    logic [15:0] immed;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        regwen;
    logic        memread;
    logic        memwrite;
    word_t       rdat1;
    word_t       rdat2;
  } idex_t;

  typedef struct packed {
    logic        valid;
    logic        regwen;
    logic        memread;
    logic        memwrite;
    logic [4:0]  rd;
    word_t       result;
    word_t       store;
    logic        neg;
    logic        over;
    logic        zero;
  } exmem_t;

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  word_t  fwd_a_s, fwd_b_s;

  // A load sitting in EX/MEM never forwards; the hazard unit stalls for it.
  function automatic word_t forward(input logic [4:0] src, input word_t regval,
                                    input exmem_t ex, input logic wb_en,
                                    input logic [4:0] wb_dst, input word_t wb_val);
    word_t val;
    if (ex.valid && ex.regwen && !ex.memread && (ex.rd != 5'd0) && (ex.rd == src)) begin
      val = ex.result;
    end else if (wb_en && (wb_dst != 5'd0) && (wb_dst == src)) begin
      val = wb_val;
    end else begin
      val = regval;
    end
    return val;
  endfunction

  // Operand forwarding for rs and rt, re-evaluated every cycle including stalls
  always_comb begin
    fwd_a_s = forward(idex_q.rs, idex_q.rdat1, exmem_q, wb_regwen, wb_rd, wb_wdat);
    fwd_b_s = forward(idex_q.rt, idex_q.rdat2, exmem_q, wb_regwen, wb_rd, wb_wdat);
  end

  assign porta  = fwd_a_s;
  assign portb  = fwd_b_s;
  assign rdat2  = fwd_b_s;
  assign aluop  = idex_q.aluop;
  assign ALUsrc = idex_q.alusrc;
  assign shamt  = idex_q.shamt;
  assign extop  = idex_q.extop;
  assign immed  = idex_q.immed;

  // ID/EX next state: flush beats stall
  always_comb begin
    idex_d = idex_q;
    if (flush) begin
      idex_d = '0;
    end else if (!stall) begin
      idex_d.valid    = id_valid;
      idex_d.aluop    = id_aluop;
      idex_d.alusrc   = id_alusrc;
      idex_d.shamt    = id_shamt;
      idex_d.extop    = id_extop;
      idex_d.immed    = id_immed;
      idex_d.rs       = id_rs;
      idex_d.rt       = id_rt;
      idex_d.rd       = id_rd;
      idex_d.regwen   = id_regwen;
      idex_d.memread  = id_memread;
      idex_d.memwrite = id_memwrite;
      idex_d.rdat1    = id_rdat1;
      idex_d.rdat2    = id_rdat2;
    end else begin
      idex_d = idex_q;
    end
  end

  // EX/MEM next state: a bubble in ID/EX becomes an all-zero EX/MEM entry
  always_comb begin
    exmem_d = exmem_q;
    if (stall) begin
      exmem_d = exmem_q;
    end else if (!idex_q.valid) begin
      exmem_d = '0;
    end else begin
      exmem_d.valid    = 1'b1;
      exmem_d.regwen   = idex_q.regwen;
      exmem_d.memread  = idex_q.memread;
      exmem_d.memwrite = idex_q.memwrite;
      exmem_d.rd       = idex_q.rd;
      exmem_d.result   = outport;
      exmem_d.store    = fwd_b_s;
      exmem_d.neg      = neg_f;
      exmem_d.over     = over_f;
      exmem_d.zero     = zero_f;
    end
  end

  // Pipeline registers with synchronous reset dominating stall and flush
  always_ff @(posedge CLK) begin
    if (RST) begin
      idex_q  <= '0;
      exmem_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
    end
  end

  assign ex_valid    = exmem_q.valid;
  assign ex_regwen   = exmem_q.regwen;
  assign ex_memread  = exmem_q.memread;
  assign ex_memwrite = exmem_q.memwrite;
  assign ex_rd       = exmem_q.rd;
  assign ex_result   = exmem_q.result;
  assign ex_store    = exmem_q.store;
  assign ex_neg      = exmem_q.neg;
  assign ex_over     = exmem_q.over;
  assign ex_zero     = exmem_q.zero;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus randomized
// traffic against an instruction-level reference model and a behavioural ALU.
module tb_alu_exec_stage;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic RST, stall, flush, id_valid, id_extop, id_regwen, id_memread, id_memwrite;
  aluop_t id_aluop, aluop;
  logic [1:0] id_alusrc, ALUsrc;
  logic [4:0] id_shamt, id_rs, id_rt, id_rd, wb_rd, shamt, ex_rd;
  logic [15:0] id_immed, immed;
  word_t id_rdat1, id_rdat2, wb_wdat, porta, portb, rdat2, outport, ex_result, ex_store;
  logic wb_regwen, extop, neg_f, over_f, zero_f;
  logic ex_valid, ex_regwen, ex_memread, ex_memwrite, ex_neg, ex_over, ex_zero;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  alu_exec_stage dut (
    .CLK(CLK), .RST(RST), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_aluop(id_aluop), .id_alusrc(id_alusrc), .id_shamt(id_shamt), .id_extop(id_extop),
    .id_immed(id_immed), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_regwen(id_regwen), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_rdat1(id_rdat1), .id_rdat2(id_rdat2), .wb_regwen(wb_regwen), .wb_rd(wb_rd),
    .wb_wdat(wb_wdat), .porta(porta), .portb(portb), .rdat2(rdat2), .aluop(aluop),
    .ALUsrc(ALUsrc), .shamt(shamt), .extop(extop), .immed(immed), .outport(outport),
    .neg_f(neg_f), .over_f(over_f), .zero_f(zero_f), .ex_valid(ex_valid),
    .ex_regwen(ex_regwen), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_rd(ex_rd), .ex_result(ex_result), .ex_store(ex_store), .ex_neg(ex_neg),
    .ex_over(ex_over), .ex_zero(ex_zero)
  );

  localparam aluop_t OP_ADD = 4'd0;
  localparam aluop_t OP_SUB = 4'd1;
  localparam aluop_t OP_AND = 4'd2;
  localparam aluop_t OP_OR  = 4'd3;

  // Behavioural ALU: returns {overflow, result}
  function automatic logic [32:0] alu_f(word_t a, word_t b, aluop_t op, logic [1:0] src,
                                        logic [4:0] sh, logic ext, logic [15:0] imm);
    word_t bb;
    word_t r;
    logic ov;
    if (src == 2'd1) bb = ext ? {{16{imm[15]}}, imm} : {16'd0, imm};
    else if (src == 2'd2) bb = {27'd0, sh};
    else bb = b;
    ov = 1'b0;
    case (op)
      OP_ADD: begin r = a + bb; ov = (a[31] == bb[31]) && (r[31] != a[31]); end
      OP_SUB: begin r = a - bb; ov = (a[31] != bb[31]) && (r[31] != a[31]); end
      OP_AND: r = a & bb;
      OP_OR:  r = a | bb;
      default: r = a ^ bb;
    endcase
    return {ov, r};
  endfunction

  logic [32:0] alu_res;
  assign alu_res = alu_f(porta, portb, aluop, ALUsrc, shamt, extop, immed);
  assign outport = alu_res[31:0];
  assign over_f  = alu_res[32];
  assign neg_f   = alu_res[31];
  assign zero_f  = (alu_res[31:0] == 32'd0);

  // Reference model: the instruction executing now and the last retired record
  typedef struct packed {
    logic v; aluop_t op; logic [1:0] src; logic [4:0] sh; logic ext; logic [15:0] imm;
    logic [4:0] rs; logic [4:0] rt; logic [4:0] rd; logic rw; logic mr; logic mw;
    word_t d1; word_t d2;
  } instr_t;
  typedef struct packed {
    logic v; logic rw; logic mr; logic mw; logic [4:0] rd;
    word_t res; word_t st; logic n; logic o; logic z;
  } ret_t;

  instr_t m_ex;
  ret_t   m_ret;

  // Newest architectural value of a register as the executing instruction sees it
  function automatic word_t pick(logic [4:0] r, word_t fallback);
    if (m_ret.v && m_ret.rw && !m_ret.mr && r != 5'd0 && m_ret.rd == r) return m_ret.res;
    if (wb_regwen && r != 5'd0 && wb_rd == r) return wb_wdat;
    return fallback;
  endfunction

  function automatic ret_t retire(instr_t i);
    ret_t r;
    logic [32:0] x;
    word_t b;
    r = '0;
    if (i.v) begin
      b = pick(i.rt, i.d2);
      x = alu_f(pick(i.rs, i.d1), b, i.op, i.src, i.sh, i.ext, i.imm);
      r = '{v: 1'b1, rw: i.rw, mr: i.mr, mw: i.mw, rd: i.rd, res: x[31:0], st: b,
            n: x[31], o: x[32], z: (x[31:0] == 32'd0)};
    end
    return r;
  endfunction

  function automatic instr_t cur_id();
    return '{v: id_valid, op: id_aluop, src: id_alusrc, sh: id_shamt, ext: id_extop,
             imm: id_immed, rs: id_rs, rt: id_rt, rd: id_rd, rw: id_regwen,
             mr: id_memread, mw: id_memwrite, d1: id_rdat1, d2: id_rdat2};
  endfunction

  // One clock: advance the model with the inputs the DUT samples, then settle
  task automatic tick();
    ret_t   nr;
    instr_t ni;
    if (RST) nr = '0;
    else if (stall) nr = m_ret;
    else nr = retire(m_ex);
    if (RST || flush) ni = '0;
    else if (stall) ni = m_ex;
    else ni = cur_id();
    @(posedge CLK);
    m_ret = nr;
    m_ex  = ni;
    #1;
  endtask

  task automatic issue(aluop_t op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                       word_t d1, word_t d2);
    id_valid = 1'b1; id_aluop = op; id_alusrc = 2'd0; id_shamt = 5'd0; id_extop = 1'b0;
    id_immed = 16'd0; id_rs = rs; id_rt = rt; id_rd = rd; id_regwen = 1'b1;
    id_memread = 1'b0; id_memwrite = 1'b0; id_rdat1 = d1; id_rdat2 = d2;
  endtask

  task automatic test_reset();
    logic [75:0] exs;
    RST = 1'b1;
    issue(OP_ADD, 5'd1, 5'd2, 5'd3, 32'hDEAD, 32'hBEEF);
    tick();
    tick();
    exs = {ex_valid, ex_regwen, ex_memread, ex_memwrite, ex_rd, ex_result, ex_store,
           ex_neg, ex_over, ex_zero};
    checks++;
    if (exs !== 76'd0) begin errors++; $display("FAIL reset_ex: got %h expected 0", exs); end
    checks++;
    if ({porta, portb, aluop, ALUsrc} !== 70'd0) begin
      errors++; $display("FAIL reset_alu: got %h/%h op %h src %h expected 0", porta, portb, aluop, ALUsrc);
    end
    RST = 1'b0;
    issue(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    tick();
    id_valid = 1'b0;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_result !== 32'd12) begin
      errors++; $display("FAIL reset_first_add: got v=%b %0d expected v=1 12", ex_valid, ex_result);
    end
  endtask

  task automatic test_ex_forward();
    issue(OP_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    tick();
    issue(OP_SUB, 5'd3, 5'd2, 5'd5, 32'd0, 32'd2);
    tick();
    checks++;
    if (porta !== 32'd12) begin errors++; $display("FAIL ex_fwd_porta: got %0d expected 12", porta); end
    id_valid = 1'b0;
    tick();
    checks++;
    if (ex_result !== 32'd10) begin errors++; $display("FAIL ex_fwd_result: got %0d expected 10", ex_result); end
  endtask

  task automatic test_wb_forward();
    id_valid = 1'b0;
    tick();
    wb_regwen = 1'b1; wb_rd = 5'd4; wb_wdat = 32'hAA;
    issue(OP_ADD, 5'd4, 5'd0, 5'd6, 32'd1, 32'd0);
    tick();
    checks++;
    if (porta !== 32'hAA) begin errors++; $display("FAIL wb_fwd: got %h expected aa", porta); end
    issue(OP_ADD, 5'd1, 5'd0, 5'd4, 32'h55, 32'd0);
    tick();
    issue(OP_ADD, 5'd4, 5'd0, 5'd7, 32'd0, 32'd0);
    tick();
    checks++;
    if (porta !== 32'h55) begin errors++; $display("FAIL fwd_priority: got %h expected 55", porta); end
    wb_regwen = 1'b0;
  endtask

  task automatic test_zero_and_load();
    issue(OP_ADD, 5'd1, 5'd0, 5'd0, 32'd9, 32'd0);
    tick();
    issue(OP_ADD, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0);
    tick();
    checks++;
    if (porta !== 32'd0) begin errors++; $display("FAIL zero_reg: got %0d expected 0", porta); end
    issue(OP_ADD, 5'd1, 5'd0, 5'd9, 32'h100, 32'd0);
    id_memread = 1'b1;
    tick();
    issue(OP_ADD, 5'd9, 5'd0, 5'd10, 32'h33, 32'd0);
    tick();
    checks++;
    if (ex_memread !== 1'b1 || ex_rd !== 5'd9 || porta !== 32'h33) begin
      errors++; $display("FAIL load_no_fwd: got mr=%b rd=%0d porta=%h expected 1 9 33", ex_memread, ex_rd, porta);
    end
  endtask

  task automatic test_stall();
    issue(OP_ADD, 5'd1, 5'd2, 5'd11, 32'd10, 32'd1);
    tick();
    issue(OP_ADD, 5'd1, 5'd2, 5'd12, 32'd20, 32'd2);
    tick();
    issue(OP_ADD, 5'd1, 5'd2, 5'd13, 32'd30, 32'd3);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (ex_result !== 32'd11 || ex_rd !== 5'd11 || porta !== 32'd20 || portb !== 32'd2) begin
        errors++; $display("FAIL stall_hold[%0d]: got res=%0d rd=%0d a=%0d b=%0d expected 11 11 20 2", k, ex_result, ex_rd, porta, portb);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (ex_result !== 32'd22 || porta !== 32'd30) begin
      errors++; $display("FAIL stall_release: got res=%0d a=%0d expected 22 30", ex_result, porta);
    end
    id_valid = 1'b0;
    tick();
    checks++;
    if (ex_result !== 32'd33 || ex_rd !== 5'd13) begin
      errors++; $display("FAIL stall_drain: got res=%0d rd=%0d expected 33 13", ex_result, ex_rd);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL stall_no_dup: got v=%b expected 0", ex_valid); end
  endtask

  task automatic test_flush_over();
    issue(OP_ADD, 5'd1, 5'd2, 5'd3, 32'h7FFFFFFF, 32'd1);
    tick();
    issue(OP_ADD, 5'd1, 5'd2, 5'd4, 32'h7FFFFFFF, 32'd1);
    tick();
    checks++;
    if (ex_over !== 1'b1 || ex_neg !== 1'b1 || ex_result !== 32'h80000000) begin
      errors++; $display("FAIL overflow: got o=%b n=%b %h expected 1 1 80000000", ex_over, ex_neg, ex_result);
    end
    stall = 1'b1; flush = 1'b1; id_valid = 1'b0;
    tick();
    checks++;
    if (ex_over !== 1'b1 || ex_rd !== 5'd3 || porta !== 32'd0) begin
      errors++; $display("FAIL flush_stall_hold: got o=%b rd=%0d a=%h expected 1 3 0", ex_over, ex_rd, porta);
    end
    stall = 1'b0; flush = 1'b0;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_over !== 1'b0) begin
      errors++; $display("FAIL flush_bubble: got v=%b o=%b expected 0 0", ex_valid, ex_over);
    end
    issue(OP_ADD, 5'd1, 5'd2, 5'd5, 32'h7FFFFFFF, 32'd1);
    id_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_over !== 1'b0) begin
      errors++; $display("FAIL invalid_over_mask: got v=%b o=%b expected 0 0", ex_valid, ex_over);
    end
  endtask

  task automatic test_random();
    logic [91:0] exp_alu;
    logic [91:0] act_alu;
    ret_t act_ex;
    for (int c = 0; c < 400; c++) begin
      RST = ($urandom_range(0, 99) < 3);
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 10);
      id_valid = ($urandom_range(0, 3) != 0);
      id_aluop = aluop_t'($urandom_range(0, 5));
      id_alusrc = 2'($urandom_range(0, 3));
      id_shamt = 5'($urandom); id_extop = 1'($urandom); id_immed = 16'($urandom);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_regwen = 1'($urandom); id_memread = ($urandom_range(0, 3) == 0);
      id_memwrite = 1'($urandom);
      id_rdat1 = $urandom; id_rdat2 = $urandom;
      wb_regwen = 1'($urandom); wb_rd = 5'($urandom_range(0, 3)); wb_wdat = $urandom;
      tick();
      exp_alu = {pick(m_ex.rs, m_ex.d1), pick(m_ex.rt, m_ex.d2), m_ex.op, m_ex.src,
                 m_ex.sh, m_ex.ext, m_ex.imm};
      act_alu = {porta, portb, aluop, ALUsrc, shamt, extop, immed};
      checks++;
      if (act_alu !== exp_alu || rdat2 !== exp_alu[59:28]) begin
        errors++; $display("FAIL rand_alu[%0d]: got %h rdat2 %h expected %h", c, act_alu, rdat2, exp_alu);
      end
      act_ex = {ex_valid, ex_regwen, ex_memread, ex_memwrite, ex_rd, ex_result, ex_store,
                ex_neg, ex_over, ex_zero};
      checks++;
      if (act_ex !== m_ret) begin
        errors++; $display("FAIL rand_ex[%0d]: got %h expected %h", c, act_ex, m_ret);
      end
    end
    RST = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    RST = 1'b1; stall = 1'b0; flush = 1'b0;
    wb_regwen = 1'b0; wb_rd = 5'd0; wb_wdat = 32'd0;
    issue(OP_ADD, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    m_ex = '0;
    m_ret = '0;
    #1;
    test_reset();
    test_ex_forward();
    test_wb_forward();
    test_zero_and_load();
    test_stall();
    test_flush_over();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
